color_rom_reader: RTL and testbench
===================================

// Module: color_rom_reader
// PURPOSE
//  Sequencer downstream of colorDetector. Reads a strip of colour tiles as ROM data:
//  - triggers one detection per tile and collects the 2-bit colour code
//  - steps the tile carrier between tiles
//  - packs 4 codes per byte and hands the bytes out over a valid/ready interface
// PARAMETERS
//  NUM_WORDS      4       bytes per read; total tiles = 4*NUM_WORDS
//  TIMEOUT_CYCLES 2**22   max cycles in WAIT_DETECT or WAIT_ADVANCE before abort
//  RETRY_LIMIT    3       max re-detections per tile on vote mismatch (COLOR_VOTE_EN only)
// PORTS
//  clk               in   1  system clock, all logic on posedge
//  reset             in   1  asynchronous, active-low reset
//  startRead         in   1  level; sampled in IDLE only
//  startDetection    out  1  1-cycle pulse to colorDetector.startDetection
//  detectionComplete in   1  1-cycle pulse from colorDetector
//  color             in   2  code: 00=R 01=G 10=B 11=Y; valid with detectionComplete
//  advanceRequest    out  1  1-cycle pulse: move carrier to next tile
//  advanceDone       in   1  1-cycle pulse: carrier in position
//  dataOut           out  8  packed byte; first tile in [1:0], fourth tile in [7:6]
//  dataValid         out  1  dataOut held stable while high
//  dataReady         in   1  consumer accept; transfer = dataValid & dataReady
//  readBusy          out  1  high in every state except IDLE
//  readDone          out  1  1-cycle pulse at end of read, normal or aborted
//  errorFlag         out  1  sticky; cleared on next accepted startRead
// BEHAVIOUR
//  Reset: all outputs 0; state=IDLE; tile count=0; word count=0; shift reg=0; timer=0.
//  IDLE:
//   - startRead=1 -> START, clear errorFlag and counters
//  START:
//   - assert startDetection for exactly 1 cycle -> WAIT_DETECT, clear timer
//  WAIT_DETECT:
//   - on detectionComplete, shift color into the byte: sr <= {color, sr[7:2]}
//   - if tile index within the byte == 3 -> EMIT
//   - else -> ADVANCE
//   - timer reaches TIMEOUT_CYCLES -> errorFlag=1 -> FINISH
//  ADVANCE:
//   - 1-cycle advanceRequest -> WAIT_ADVANCE, clear timer
//  WAIT_ADVANCE:
//   - advanceDone -> START
//   - timeout -> errorFlag=1 -> FINISH
//  EMIT:
//   - dataOut=sr, dataValid=1
//   - hold until dataReady; no new detection while stalled
//   - on transfer, dataValid=0 on the next cycle
//   - last word -> FINISH; otherwise -> ADVANCE
//  FINISH:
//   - readDone pulse for 1 cycle -> IDLE
//   - carrier is not advanced after the last tile
//  Latency: startDetection goes high 1 cycle after startRead is sampled in IDLE.
//   dataValid goes high 1 cycle after the 4th detectionComplete of a byte.
//  Edge cases:
//   - detectionComplete/advanceDone outside their WAIT state: ignored
//   - advanceDone coincident with advanceRequest: ignored; only WAIT_ADVANCE counts it
//   - startRead while busy: ignored
//   - dataReady without dataValid: no effect
//   - counters: tile index 2 bits (wraps 3->0 per byte); word count sized clog2(NUM_WORDS+1)
//   - timer saturates, never wraps
//   - reset mid-read: immediate return to reset values; a pending byte is discarded
// CONFIGURATION
//  COLOR_VOTE_EN defined:
//   - each tile is detected twice (two START/WAIT_DETECT passes) and both codes compared
//   - match -> accept the code
//   - mismatch -> redo both passes, up to RETRY_LIMIT times
//   - retries exhausted -> errorFlag=1, accept the second code, continue the read
//  COLOR_VOTE_EN undefined:
//   - single detection per tile; RETRY_LIMIT unused; no vote logic synthesised
// TESTING
//  1 NUM_WORDS=1, codes 00,01,10,11, dataReady=1 -> dataOut=8'hE4, 3 advanceRequest pulses, readDone
//  2 NUM_WORDS=2, dataReady low 50 cycles on byte 0 -> dataOut/dataValid stable, no startDetection, then byte 1
//  3 no detectionComplete, TIMEOUT_CYCLES=100 -> errorFlag=1, readDone at cycle ~101, dataValid never high
//  4 reset low during WAIT_ADVANCE of tile 2 -> all outputs 0 immediately; new startRead starts at tile 0
//  5 COLOR_VOTE_EN, tile 0 reads 01 then 10 (x4), RETRY_LIMIT=3 -> 8 startDetection pulses, errorFlag=1, code 10 packed
//  6 startRead pulsed mid-read, stray advanceDone in WAIT_DETECT -> ignored; byte value unchanged

Source files
------------

// File: rtl/color_rom_reader_if.sv
// ============================================================================
// color_rom_reader_if : detector, carrier and byte-stream signals of the reader
// Rev 1.0
// ============================================================================
`default_nettype none

interface color_rom_reader_if;
   logic       startRead;
   logic       startDetection;
   logic       detectionComplete;
   logic [1:0] color;
   logic       advanceRequest;
   logic       advanceDone;
   logic [7:0] dataOut;
   logic       dataValid;
   logic       dataReady;
   logic       readBusy;
   logic       readDone;
   logic       errorFlag;

   modport master (
      input  startRead, detectionComplete, color, advanceDone, dataReady,
      output startDetection, advanceRequest, dataOut, dataValid,
             readBusy, readDone, errorFlag
   );

   modport slave (
      output startRead, detectionComplete, color, advanceDone, dataReady,
      input  startDetection, advanceRequest, dataOut, dataValid,
             readBusy, readDone, errorFlag
   );
endinterface

`default_nettype wire

// File: rtl/color_rom_reader.sv
// ============================================================================
// color_rom_reader : sequences tile detections, packs 4 colour codes per byte.
// Optional macro COLOR_VOTE_EN: detect each tile twice, retry on mismatch.
// Rev 1.0
// ============================================================================
`default_nettype none

module color_rom_reader #(
   parameter int NUM_WORDS      = 4,
   parameter int TIMEOUT_CYCLES = 2**22
`ifdef COLOR_VOTE_EN
   ,
   parameter int RETRY_LIMIT    = 3
`endif
) (
   input  logic               clk,
   input  logic               reset,
   color_rom_reader_if.master bus
);
   localparam int WORD_W  = $clog2(NUM_WORDS + 1);
   localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WORD_W-1:0]  LAST_WORD = WORD_W'(NUM_WORDS - 1);
   localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CYCLES);

   localparam logic [2:0] S_IDLE         = 3'd0;
   localparam logic [2:0] S_START        = 3'd1;
   localparam logic [2:0] S_WAIT_DETECT  = 3'd2;
   localparam logic [2:0] S_ADVANCE      = 3'd3;
   localparam logic [2:0] S_WAIT_ADVANCE = 3'd4;
   localparam logic [2:0] S_EMIT         = 3'd5;
   localparam logic [2:0] S_FINISH       = 3'd6;

   logic [2:0]         state;
   logic [1:0]         tile_idx;
   logic [WORD_W-1:0]  word_cnt;
   logic [7:0]         sr;
   logic [TIMER_W-1:0] timer;
   logic               error_flag;
   logic               timed_out;

   // accept: the code for the current tile is final this cycle
   // redetect: run another detection pass on the same tile
   logic               accept;
   logic [1:0]         accept_code;
   logic               redetect;
   logic               vote_error;

   assign timed_out = (timer == TIMER_MAX);

`ifdef COLOR_VOTE_EN
   localparam int RETRY_W = (RETRY_LIMIT < 1) ? 1 : $clog2(RETRY_LIMIT + 1);

   logic               second_pass;
   logic [1:0]         first_code;
   logic [RETRY_W-1:0] retry_cnt;

   always_comb begin
      accept      = 1'b0;
      accept_code = bus.color;
      redetect    = 1'b0;
      vote_error  = 1'b0;
      if (state == S_WAIT_DETECT && bus.detectionComplete) begin
         if (!second_pass) begin
            redetect = 1'b1;
         end else if (bus.color == first_code) begin
            accept = 1'b1;
         end else if (retry_cnt < RETRY_W'(RETRY_LIMIT)) begin
            redetect = 1'b1;
         end else begin
            accept     = 1'b1;
            vote_error = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         second_pass <= 1'b0;
         first_code  <= 2'b00;
         retry_cnt   <= '0;
      end else if (state == S_IDLE) begin
         second_pass <= 1'b0;
         retry_cnt   <= '0;
      end else if (state == S_WAIT_DETECT && bus.detectionComplete) begin
         if (!second_pass) begin
            second_pass <= 1'b1;
            first_code  <= bus.color;
         end else begin
            second_pass <= 1'b0;
            retry_cnt   <= accept ? '0 : retry_cnt + 1'b1;
         end
      end
   end
`else
   always_comb begin
      accept      = (state == S_WAIT_DETECT) && bus.detectionComplete;
      accept_code = bus.color;
      redetect    = 1'b0;
      vote_error  = 1'b0;
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         tile_idx   <= 2'd0;
         word_cnt   <= '0;
         sr         <= 8'h00;
         timer      <= '0;
         error_flag <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.startRead) begin
                  state      <= S_START;
                  error_flag <= 1'b0;
                  tile_idx   <= 2'd0;
                  word_cnt   <= '0;
               end
            end
            S_START: begin
               state <= S_WAIT_DETECT;
               timer <= '0;
            end
            S_WAIT_DETECT: begin
               if (accept) begin
                  sr       <= {accept_code, sr[7:2]};
                  tile_idx <= tile_idx + 2'd1;
                  state    <= (tile_idx == 2'd3) ? S_EMIT : S_ADVANCE;
                  if (vote_error) error_flag <= 1'b1;
               end else if (redetect) begin
                  state <= S_START;
               end else if (timed_out) begin
                  error_flag <= 1'b1;
                  state      <= S_FINISH;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            S_ADVANCE: begin
               state <= S_WAIT_ADVANCE;
               timer <= '0;
            end
            S_WAIT_ADVANCE: begin
               if (bus.advanceDone) begin
                  state <= S_START;
               end else if (timed_out) begin
                  error_flag <= 1'b1;
                  state      <= S_FINISH;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            S_EMIT: begin
               // sr is frozen here, so dataOut stays stable across a stall
               if (bus.dataReady) begin
                  word_cnt <= word_cnt + 1'b1;
                  state    <= (word_cnt == LAST_WORD) ? S_FINISH : S_ADVANCE;
               end
            end
            S_FINISH: state <= S_IDLE;
            default:  state <= S_IDLE;
         endcase
      end
   end

   assign bus.startDetection = (state == S_START);
   assign bus.advanceRequest = (state == S_ADVANCE);
   assign bus.dataValid      = (state == S_EMIT);
   assign bus.dataOut        = sr;
   assign bus.readBusy       = (state != S_IDLE);
   assign bus.readDone       = (state == S_FINISH);
   assign bus.errorFlag      = error_flag;

endmodule

`default_nettype wire

// File: tb/tb_color_rom_reader.sv
// ============================================================================
// tb_color_rom_reader : scoreboard bench with detector/carrier responder model.
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_color_rom_reader;
   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   color_rom_reader_if bus ();

   color_rom_reader #(
      .NUM_WORDS      (2),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int         n_pass = 0;
   int         n_total = 0;
   int         n_startdet = 0;
   int         n_advreq = 0;
   int         det_timer = 0;
   int         adv_timer = 0;
   bit         det_en = 1'b1;
   bit         stray = 1'b0;
   bit         seen_valid = 1'b0;
   logic [1:0] code_q[$];
   logic [7:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic check_outputs_zero(input string name);
      check(name, 32'({bus.startDetection, bus.advanceRequest, bus.dataOut, bus.dataValid,
                       bus.readBusy, bus.readDone, bus.errorFlag}), 32'd0);
   endtask

   task automatic start_read();
      @(posedge clk); #1 bus.startRead = 1'b1;
      @(posedge clk); #1 bus.startRead = 1'b0;
      @(negedge clk);
      check("start_latency", 32'({bus.startDetection, bus.readBusy, bus.errorFlag}), 32'b110);
   endtask

   task automatic wait_done(input string name, input int budget, output int cycles);
      cycles = 0;
      while (!bus.readDone && cycles < budget) begin
         @(negedge clk);
         cycles++;
      end
      check(name, 32'(bus.readDone), 32'd1);
   endtask

   // Colour detector and tile carrier: respond a few cycles after each request
   initial begin : env
      bus.detectionComplete = 1'b0;
      bus.advanceDone       = 1'b0;
      bus.color             = 2'b00;
      forever begin
         @(negedge clk);
         if (!reset) begin
            det_timer = 0;
            adv_timer = 0;
         end else begin
            if (bus.startDetection) begin
               n_startdet++;
               if (det_en) det_timer = 3;
            end
            if (bus.advanceRequest) begin
               n_advreq++;
               adv_timer = 2;
            end
         end
         @(posedge clk); #1;
         bus.detectionComplete = 1'b0;
         bus.advanceDone       = 1'b0;
         bus.color             = 2'b00;
         if (det_timer > 0) begin
            det_timer--;
            if (det_timer == 2 && stray) bus.advanceDone = 1'b1;
            if (det_timer == 0) begin
               bus.detectionComplete = 1'b1;
               if (code_q.size() > 0) bus.color = code_q.pop_front();
            end
         end
         if (adv_timer > 0) begin
            adv_timer--;
            if (adv_timer == 0) bus.advanceDone = 1'b1;
         end
      end
   end

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (reset && bus.dataValid) begin
            seen_valid = 1'b1;
            if (bus.dataReady) begin
               if (exp_q.size() == 0) check("byte_queue_depth", 32'(exp_q.size()), 32'd1);
               else check("byte_value", 32'(bus.dataOut), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", n_pass, n_total);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int cyc;
      int sd0;
      int ar0;
      bit stable;
      bus.startRead = 1'b0;
      bus.dataReady = 1'b0;

      #2 reset = 1'b0;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset_outputs");
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      check_outputs_zero("idle_after_reset");

`ifdef COLOR_VOTE_EN
      // tile 0 disagrees on every pair; remaining tiles agree on 00
      for (int i = 0; i < 4; i++) begin
         code_q.push_back(2'b01);
         code_q.push_back(2'b10);
      end
      for (int i = 0; i < 14; i++) code_q.push_back(2'b00);
      exp_q.push_back(8'h02); exp_q.push_back(8'h00);
      bus.dataReady = 1'b1;
      sd0 = n_startdet;
      start_read();
      wait_done("t5_done", 1500, cyc);
      check("t5_errorFlag", 32'(bus.errorFlag), 32'd1);
      check("t5_startDetection_count", n_startdet - sd0, 22);
      check("t5_bytes_left", exp_q.size(), 0);
`else
      // Test 1: two bytes, consumer always ready
      code_q = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00};
      exp_q.push_back(8'hE4); exp_q.push_back(8'h1B);
      bus.dataReady = 1'b1;
      sd0 = n_startdet; ar0 = n_advreq;
      start_read();
      wait_done("t1_done", 600, cyc);
      check("t1_errorFlag", 32'(bus.errorFlag), 32'd0);
      check("t1_startDetection_count", n_startdet - sd0, 8);
      check("t1_advanceRequest_count", n_advreq - ar0, 7);
      check("t1_bytes_left", exp_q.size(), 0);
      @(negedge clk);
      check("t1_done_pulse_width", 32'({bus.readDone, bus.readBusy}), 32'd0);

      // Test 2: consumer stalls on byte 0
      code_q = '{2'b10, 2'b00, 2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
      exp_q.push_back(8'h72); exp_q.push_back(8'h55);
      bus.dataReady = 1'b0;
      start_read();
      cyc = 0;
      while (!bus.dataValid && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check("t2_valid_seen", 32'(bus.dataValid), 32'd1);
      check("t2_byte0_held", 32'(bus.dataOut), 32'h72);
      sd0 = n_startdet; ar0 = n_advreq; stable = 1'b1;
      repeat (50) begin
         @(negedge clk);
         if (!bus.dataValid || bus.dataOut !== 8'h72) stable = 1'b0;
      end
      check("t2_stall_stable", 32'(stable), 32'd1);
      check("t2_stall_no_detect", n_startdet - sd0, 0);
      check("t2_stall_no_advance", n_advreq - ar0, 0);
      @(posedge clk); #1 bus.dataReady = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("t2_valid_drop", 32'(bus.dataValid), 32'd0);
      wait_done("t2_done", 300, cyc);
      check("t2_bytes_left", exp_q.size(), 0);

      // Test 3: detector never answers
      det_en = 1'b0; seen_valid = 1'b0;
      start_read();
      wait_done("t3_done", 300, cyc);
      check("t3_errorFlag", 32'(bus.errorFlag), 32'd1);
      check("t3_timeout_window", 32'(cyc >= 95 && cyc <= 110), 32'd1);
      check("t3_no_valid", 32'(seen_valid), 32'd0);
      det_en = 1'b1;
      repeat (3) @(negedge clk);
      check("t3_error_sticky", 32'({bus.errorFlag, bus.readBusy}), 32'b10);

      // Test 4: reset while waiting for the carrier to reach tile 2
      code_q = '{2'b01, 2'b01, 2'b01};
      ar0 = n_advreq;
      start_read();
      cyc = 0;
      while ((n_advreq - ar0) < 2 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check("t4_reached_tile2", n_advreq - ar0, 2);
      @(posedge clk); #2 reset = 1'b0;
      #1 check_outputs_zero("t4_async_reset_outputs");
      code_q.delete();
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      check("t4_idle_after_reset", 32'(bus.readBusy), 32'd0);
      code_q = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b01};
      exp_q.push_back(8'hFF); exp_q.push_back(8'h40);
      sd0 = n_startdet;
      start_read();
      wait_done("t4_done", 600, cyc);
      check("t4_startDetection_count", n_startdet - sd0, 8);
      check("t4_bytes_left", exp_q.size(), 0);

      // Test 6: startRead mid-read and stray advanceDone during detection
      code_q = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b10, 2'b10, 2'b00, 2'b11};
      exp_q.push_back(8'h39); exp_q.push_back(8'hCA);
      stray = 1'b1;
      sd0 = n_startdet; ar0 = n_advreq;
      start_read();
      repeat (6) @(negedge clk);
      check("t6_busy_midread", 32'(bus.readBusy), 32'd1);
      @(posedge clk); #1 bus.startRead = 1'b1;
      repeat (2) @(posedge clk);
      #1 bus.startRead = 1'b0;
      wait_done("t6_done", 600, cyc);
      stray = 1'b0;
      check("t6_errorFlag", 32'(bus.errorFlag), 32'd0);
      check("t6_startDetection_count", n_startdet - sd0, 8);
      check("t6_advanceRequest_count", n_advreq - ar0, 7);
      check("t6_bytes_left", exp_q.size(), 0);
      repeat (3) @(negedge clk);
      check("t6_no_restart", 32'(bus.readBusy), 32'd0);
`endif

      repeat (2) @(negedge clk);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

`default_nettype wire
